// File: rtl/dispensador_cambio.sv
// Change payout stage: pays a loaded amount as greedy 2-unit/1-unit coin pulses,
// each confirmed by the hopper sensor. Macro DISP_TIMEOUT_EN enables a confirmation timeout with sticky error.
module dispensador_cambio #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cargar,
  input  logic [3:0] cambio,
  input  logic       moneda_ok,
  output logic       sal_m2,
  output logic       sal_m1,
  output logic [3:0] pendiente,
  output logic       ocupado,
  output logic       hecho,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
`ifdef DISP_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
`endif

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_pend,  w_pend_nxt;
  logic [1:0]  r_coin,  w_coin_nxt;
  logic [15:0] r_cnt,   w_cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_coin  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_coin  <= w_coin_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every next-value signal is given a hold default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_coin_nxt  = r_coin;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (cargar) begin
          if (cambio != 4'd0) begin
            w_pend_nxt  = cambio;
            w_state_nxt = S_SELECT;
          end else begin
            w_pend_nxt  = '0;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_SELECT: begin
        w_coin_nxt  = (r_pend >= 4'd2) ? 2'd2 : 2'd1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_PULSE;
      end

      S_PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_ACK;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      // The coin never exceeds the amount owed, so the subtraction cannot wrap.
      S_WAIT_ACK: begin
        if (moneda_ok) begin
          w_pend_nxt  = r_pend - {2'b00, r_coin};
          w_cnt_nxt   = '0;
          w_state_nxt = (r_pend == {2'b00, r_coin}) ? S_DONE : S_GAP;
        end
`ifdef DISP_TIMEOUT_EN
        else if (r_cnt == TIMEOUT_LIM) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
`endif
      end

      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SELECT;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;

      S_ERROR: w_state_nxt = S_ERROR;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sal_m2    = (r_state == S_PULSE) && (r_coin == 2'd2);
  assign sal_m1    = (r_state == S_PULSE) && (r_coin == 2'd1);
  assign pendiente = r_pend;
  assign hecho     = (r_state == S_DONE);
  assign ocupado   = (r_state == S_SELECT) || (r_state == S_PULSE) ||
                     (r_state == S_WAIT_ACK) || (r_state == S_GAP) ||
                     (r_state == S_ERROR);
`ifdef DISP_TIMEOUT_EN
  assign error = (r_state == S_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_dispensador_cambio.sv
// Bench for dispensador_cambio: directed scenarios plus randomized sales checked
// against a greedy coin-count model.
module tb_dispensador_cambio;

  localparam int P  = 4;
  localparam int G  = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cargar = 1'b0;
  logic [3:0] cambio = '0;
  logic       moneda_ok = 1'b0;
  logic       sal_m2, sal_m1, ocupado, hecho, error;
  logic [3:0] pendiente;

  int total = 0;
  int bad   = 0;

  dispensador_cambio #(
    .PULSE_CYCLES  (P),
    .GAP_CYCLES    (G),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cargar   (cargar),
    .cambio   (cambio),
    .moneda_ok(moneda_ok),
    .sal_m2   (sal_m2),
    .sal_m1   (sal_m1),
    .pendiente(pendiente),
    .ocupado  (ocupado),
    .hecho    (hecho),
    .error    (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({sal_m2, sal_m1, pendiente, ocupado, hecho, error} !== 9'b0) begin
      bad++;
      $display("FAIL reset_hold: outs=%b want all zero",
               {sal_m2, sal_m1, pendiente, ocupado, hecho, error});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sal_m2, sal_m1, pendiente, ocupado, hecho, error} !== 9'b0) begin
      bad++;
      $display("FAIL reset_idle: outs=%b want all zero",
               {sal_m2, sal_m1, pendiente, ocupado, hecho, error});
    end
  endtask

  // One complete sale. mode 1: cargar(9) poked in GAP; mode 2: stray sensor in PULSE and GAP.
  task automatic pay_and_check(input logic [3:0] amt, input int ack_dly, input bit rnd_dly,
                               input int mode, input string tag);
    int n2, owed, coin, w, t, d, exp_wait;
    logic act;
    n2   = amt / 2;
    owed = amt;
    cargar = 1'b1;
    cambio = amt;
    @(negedge clk);
    cargar = 1'b0;
    cambio = 4'($urandom);
    total++;
    if (ocupado !== 1'b1 || pendiente !== amt) begin
      bad++;
      $display("FAIL %s load: ocupado=%b pendiente=%0d want 1/%0d", tag, ocupado, pendiente, amt);
    end
    exp_wait = 1;
    for (int c = 0; owed > 0 && c < 16; c++) begin
      coin = (c < n2) ? 2 : 1;
      t = 0;
      while (!(sal_m1 === 1'b1 || sal_m2 === 1'b1) && t < 50) begin
        @(negedge clk);
        t++;
      end
      total++;
      if (t != exp_wait) begin
        bad++;
        $display("FAIL %s coin%0d start: waited %0d want %0d", tag, c, t, exp_wait);
      end
      total++;
      if ({sal_m2, sal_m1} !== ((coin == 2) ? 2'b10 : 2'b01) || pendiente !== 4'(owed)) begin
        bad++;
        $display("FAIL %s coin%0d sel: m2m1=%b pend=%0d want coin %0d pend %0d",
                 tag, c, {sal_m2, sal_m1}, pendiente, coin, owed);
      end
      w = 0;
      act = (coin == 2) ? sal_m2 : sal_m1;
      while (act === 1'b1 && w < 100) begin
        if (sal_m1 === 1'b1 && sal_m2 === 1'b1) begin
          total++;
          bad++;
          $display("FAIL %s both_actuators: m2=1 m1=1 want at most one", tag);
        end
        w++;
        if (mode == 2 && (w == 1 || w == P)) moneda_ok = 1'b1;
        @(negedge clk);
        moneda_ok = 1'b0;
        act = (coin == 2) ? sal_m2 : sal_m1;
      end
      total++;
      if (w != P) begin
        bad++;
        $display("FAIL %s coin%0d width: %0d want %0d", tag, c, w, P);
      end
      total++;
      if (pendiente !== 4'(owed) || {sal_m2, sal_m1} !== 2'b00 || ocupado !== 1'b1) begin
        bad++;
        $display("FAIL %s coin%0d wait_ack: pend=%0d m2m1=%b ocupado=%b want %0d/00/1",
                 tag, c, pendiente, {sal_m2, sal_m1}, ocupado, owed);
      end
      d = rnd_dly ? int'($urandom_range(0, 5)) : ack_dly;
      repeat (d) @(negedge clk);
      moneda_ok = 1'b1;
      @(negedge clk);
      moneda_ok = 1'b0;
      owed -= coin;
      total++;
      if (pendiente !== 4'(owed)) begin
        bad++;
        $display("FAIL %s coin%0d ack: pend=%0d want %0d", tag, c, pendiente, owed);
      end
      if (owed == 0) begin
        total++;
        if (hecho !== 1'b1 || ocupado !== 1'b0) begin
          bad++;
          $display("FAIL %s done: hecho=%b ocupado=%b want 1/0", tag, hecho, ocupado);
        end
        @(negedge clk);
        total++;
        if (hecho !== 1'b0 || ocupado !== 1'b0 || error !== 1'b0) begin
          bad++;
          $display("FAIL %s idle: hecho=%b ocupado=%b error=%b want 0/0/0",
                   tag, hecho, ocupado, error);
        end
      end else begin
        total++;
        if (hecho !== 1'b0 || ocupado !== 1'b1) begin
          bad++;
          $display("FAIL %s gap: hecho=%b ocupado=%b want 0/1", tag, hecho, ocupado);
        end
        exp_wait = G + 1;
        if (mode != 0) begin
          if (mode == 1) begin
            cargar = 1'b1;
            cambio = 4'd9;
          end else begin
            moneda_ok = 1'b1;
          end
          @(negedge clk);
          cargar    = 1'b0;
          moneda_ok = 1'b0;
          total++;
          if (pendiente !== 4'(owed) || ocupado !== 1'b1) begin
            bad++;
            $display("FAIL %s gap_poke: pend=%0d ocupado=%b want %0d/1",
                     tag, pendiente, ocupado, owed);
          end
          exp_wait = G;
        end
      end
    end
  endtask

  task automatic test_greedy();
    pay_and_check(4'd5, 2, 1'b0, 0, "greedy5");
  endtask

  task automatic test_zero();
    cargar = 1'b1;
    cambio = 4'd0;
    @(negedge clk);
    cargar = 1'b0;
    total++;
    if (hecho !== 1'b1 || ocupado !== 1'b0 || {sal_m2, sal_m1} !== 2'b00 || pendiente !== 4'd0) begin
      bad++;
      $display("FAIL zero_done: hecho=%b ocupado=%b m2m1=%b pend=%0d want 1/0/00/0",
               hecho, ocupado, {sal_m2, sal_m1}, pendiente);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (hecho !== 1'b0 || ocupado !== 1'b0 || {sal_m2, sal_m1} !== 2'b00) begin
        bad++;
        $display("FAIL zero_after%0d: hecho=%b ocupado=%b m2m1=%b want 0/0/00",
                 i, hecho, ocupado, {sal_m2, sal_m1});
      end
    end
  endtask

  task automatic test_lockout();
    pay_and_check(4'd3, 1, 1'b0, 1, "lockout");
  endtask

  task automatic test_stray();
    pay_and_check(4'd4, 3, 1'b0, 2, "stray");
  endtask

  task automatic test_reset_mid();
    cargar = 1'b1;
    cambio = 4'd4;
    @(negedge clk);
    cargar = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (sal_m2 !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pulse: m2=%b want 1", sal_m2);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (sal_m2 !== 1'b0 || pendiente !== 4'd0 || ocupado !== 1'b0 || hecho !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort: m2=%b pend=%0d ocupado=%b hecho=%b want 0/0/0/0",
               sal_m2, pendiente, ocupado, hecho);
    end
    pay_and_check(4'd1, 0, 1'b0, 0, "after_rst");
  endtask

`ifdef DISP_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    pay_and_check(4'd1, TO, 1'b0, 0, "ack_at_limit");
    cargar = 1'b1;
    cambio = 4'd1;
    @(negedge clk);
    cargar = 1'b0;
    t = 0;
    while (sal_m1 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    t = 0;
    while (sal_m1 === 1'b1 && t < 20) begin @(negedge clk); t++; end
    t = 0;
    while (error !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    total++;
    if (t != TO + 1) begin
      bad++;
      $display("FAIL timeout_latency: %0d want %0d", t, TO + 1);
    end
    total++;
    if (pendiente !== 4'd1 || ocupado !== 1'b1 || {sal_m2, sal_m1} !== 2'b00 || hecho !== 1'b0) begin
      bad++;
      $display("FAIL timeout_state: pend=%0d ocupado=%b m2m1=%b hecho=%b want 1/1/00/0",
               pendiente, ocupado, {sal_m2, sal_m1}, hecho);
    end
    cargar    = 1'b1;
    cambio    = 4'd7;
    moneda_ok = 1'b1;
    repeat (3) @(negedge clk);
    cargar    = 1'b0;
    moneda_ok = 1'b0;
    total++;
    if (error !== 1'b1 || pendiente !== 4'd1 || ocupado !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: error=%b pend=%0d ocupado=%b want 1/1/1",
               error, pendiente, ocupado);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (error !== 1'b0 || ocupado !== 1'b0 || pendiente !== 4'd0) begin
      bad++;
      $display("FAIL timeout_reset: error=%b ocupado=%b pend=%0d want 0/0/0",
               error, ocupado, pendiente);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] amt;
    for (int i = 0; i < 12; i++) begin
      amt = 4'($urandom_range(1, 15));
      pay_and_check(amt, 0, 1'b1, 0, "random");
    end
    pay_and_check(4'd15, 0, 1'b1, 0, "max15");
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_zero();
    test_lockout();
    test_stray();
    test_reset_mid();
`ifdef DISP_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispensador_cambio.md
# dispensador_cambio

Change-payout stage sitting directly downstream of the vending top level. It captures the `cambio` amount when a sale completes and pays it out as a sequence of 2-unit and 1-unit coins. Each coin is a timed actuator pulse to the hopper, and each pulse must be confirmed by the hopper's coin sensor before the next one. It reports busy/done/error status back to the controller.

## Interface

Parameters:
- `PULSE_CYCLES`, 4: width of each actuator pulse in cycles (1..65535).
- `GAP_CYCLES`, 2: idle cycles between a confirmed coin and the next pulse (1..65535).
- `TIMEOUT_CYCLES`, 1000: maximum cycles waiting for sensor confirmation (1..65535). Used only with `DISP_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cargar`  in  1: load strobe; top level drives `listoA | listoB`.
- `cambio`  in  4: change amount, unsigned, sampled with `cargar`.
- `moneda_ok`  in  1: hopper sensor; one coin has left the hopper.
- `sal_m2`  out  1: actuator, 2-unit coin.
- `sal_m1`  out  1: actuator, 1-unit coin.
- `pendiente`  out  4: amount still owed.
- `ocupado`  out  1: payout in progress.
- `hecho`  out  1: one-cycle pulse when payout is complete.
- `error`  out  1: sticky hopper fault.

## Operation

States: IDLE, SELECT, PULSE, WAIT_ACK, GAP, DONE, ERROR. All outputs are Moore-decoded from registered state and counters.

- **Reset:** state=IDLE. `pendiente`=0, `sal_m2`=`sal_m1`=0, `ocupado`=0, `hecho`=0, `error`=0. Coin-select register=0 and counters=0.
- **Reset mid-operation:** abort immediately to the reset values. No partial state survives, and the remaining payout is lost.
- **IDLE:**
  - `cargar`=1 and `cambio`≠0: load `pendiente`←`cambio` and go to SELECT.
  - `cargar`=1 and `cambio`=0: go to DONE with `pendiente`=0.
  - Otherwise stay in IDLE.
- **SELECT:** set coin=2 if `pendiente`≥2, else coin=1. Go to PULSE and clear the counter.
- **PULSE:** drive `sal_m2` (coin=2) or `sal_m1` (coin=1) high for exactly `PULSE_CYCLES` cycles, then go to WAIT_ACK. Both actuators are never high together.
- **WAIT_ACK:** on `moneda_ok`=1, set `pendiente`←`pendiente`−coin. If the result is 0, go to DONE; otherwise go to GAP.
- **GAP:** stay `GAP_CYCLES` cycles, then go to SELECT.
- **DONE:** `hecho`=1 for this cycle only, then go to IDLE.
- **ERROR:** `error`=1, `ocupado`=1, actuators 0, `pendiente` frozen. Exit only by reset.
- **`ocupado`:** 1 in SELECT, PULSE, WAIT_ACK, GAP and ERROR; 0 in IDLE and DONE.
- **Ignored inputs:**
  - `cargar` is ignored in every state except IDLE. A new sale cannot overwrite a payout in progress.
  - `moneda_ok` is ignored outside WAIT_ACK, including during PULSE. A sensor pulse aligned with the last PULSE cycle is not counted.
- **Payout order:** greedy, largest coins first. `cambio`=15 gives seven 2-unit coins then one 1-unit coin. Subtraction never underflows, because coin ≤ `pendiente` by construction.

## Timing

- `cargar` high in cycle 0 gives SELECT in cycle 1 (`ocupado`=1, `pendiente`=`cambio`).
- PULSE occupies cycles 2..1+P, where P=`PULSE_CYCLES`.
- First WAIT_ACK cycle is 2+P.
- `moneda_ok` sampled high in cycle k:
  - `pendiente` updates in cycle k+1.
  - Final coin: DONE (`hecho`=1) in k+1, IDLE in k+2.
  - Otherwise: GAP in k+1..k+G, SELECT in k+G+1, next pulse starts at k+G+2 (G=`GAP_CYCLES`).
- Zero-change load: `cargar` in cycle 0 gives `hecho`=1 in cycle 1.
- Back-to-back sales: `cargar` may be accepted again in the cycle after DONE.

## Configuration

- Macro `DISP_TIMEOUT_EN`.
- **Defined:** a 16-bit counter clears on entry to WAIT_ACK and increments each cycle without `moneda_ok`.
  - Reaching `TIMEOUT_CYCLES` with no confirmation moves the state to ERROR in the next cycle.
  - `moneda_ok` in the same cycle the count is reached wins; the coin is counted and no error is raised.
- **Undefined:** WAIT_ACK waits indefinitely. ERROR is unreachable and `error` is tied to 0.

## Test plan

- **Greedy split:** reset, `cambio`=5 with `cargar` in cycle 0, ack 3 cycles after each pulse ends. Expect `sal_m2` pulse, `sal_m2` pulse, `sal_m1` pulse, each exactly 4 cycles wide. `pendiente` steps 5→3→1→0, one `hecho` pulse, then `ocupado`=0.
- **Zero change:** `cambio`=0 with `cargar` in cycle 0. Expect `hecho`=1 in cycle 1 only, no actuator activity, `ocupado` never 1.
- **Busy lockout:** during a `cambio`=3 payout, assert `cargar` with `cambio`=9 in GAP. Expect it ignored: payout finishes after 2+1 coins, `pendiente` never shows 9.
- **Stray sensor:** `moneda_ok` pulsed during PULSE and during GAP. Expect `pendiente` unchanged until a WAIT_ACK-cycle ack.
- **Timeout (`DISP_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** `cambio`=1, no ack. Expect ERROR entered 9 cycles after WAIT_ACK entry, `error`=1, `pendiente`=1 held. `cargar` is ignored until reset, and reset clears `error`.
- **Reset mid-pulse:** `cambio`=4, assert `reset` in the 2nd PULSE cycle. Next cycle: `sal_m2`=0, `pendiente`=0, `ocupado`=0. A following `cambio`=1 load pays one `sal_m1` coin normally.
